// File: rtl/aes_wb_sequencer.sv
// aes_wb_sequencer: Wishbone master running one AES block op on aes_top.
// Define AES_SEQ_KEY_CACHE_EN to skip rewriting an unchanged key.
`timescale 1ns/1ps
module aes_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_data,
  input  logic         req_decrypt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  output logic [3:0]   wbm_sel_o,
  output logic         wbm_we_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  input  logic         wbm_ack_i,
  input  logic         wbm_err_i,
  input  logic [31:0]  wbm_dat_i
);

  typedef enum logic [2:0] {
    IDLE, WR_KEY, WR_DIN, WR_CTRL, RD_STAT, RD_DOUT, RESP
  } state_e;

  localparam logic [31:0] OFS_DIN  = 32'h10;
  localparam logic [31:0] OFS_CTRL = 32'h20;
  localparam logic [31:0] OFS_STAT = 32'h24;
  localparam logic [31:0] OFS_DOUT = 32'h28;
  localparam logic [7:0]  POLL_LAST = 8'(POLL_MAX - 1);

  state_e       state_q;
  logic [1:0]   idx_q;
  logic [7:0]   poll_q;
  logic [127:0] key_q, din_q, rsp_data_q;
  logic         dec_q;
  logic         req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [31:0]  adr_q, dat_q;
  logic [3:0]   sel_q;
  logic         we_q, cyc_q, stb_q;

  logic         bus_ack, bus_err, timeout, cache_hit;
  logic [1:0]   idx_n;
  logic [31:0]  nxt_ofs;

  // Word 0 is the most significant 32 bits of a block.
  function automatic logic [31:0] word_of(input logic [127:0] b,
                                          input logic [1:0]   i);
    return b[{~i, 5'd0} +: 32];
  endfunction

  assign bus_ack = stb_q & wbm_ack_i;
  assign bus_err = stb_q & wbm_err_i;
  assign idx_n   = idx_q + 2'd1;
  assign nxt_ofs = {28'd0, idx_n, 2'b00};
  assign timeout = (state_q == RD_STAT) & bus_ack & ~wbm_dat_i[0]
                 & (poll_q == POLL_LAST);

`ifdef AES_SEQ_KEY_CACHE_EN
  logic [127:0] kc_key_q;
  logic         kc_vld_q;
  logic         key_done;

  assign key_done = (state_q == WR_KEY) & bus_ack & (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kc_vld_q <= 1'b0;
      kc_key_q <= '0;
    end else if (bus_err || timeout) begin
      kc_vld_q <= 1'b0;
    end else if (key_done) begin
      kc_vld_q <= 1'b1;
      kc_key_q <= key_q;
    end
  end

  assign cache_hit = kc_vld_q && (req_key == kc_key_q);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      poll_q      <= '0;
      key_q       <= '0;
      din_q       <= '0;
      dec_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else if (bus_err || timeout) begin
      state_q     <= RESP;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= 1'b1;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            key_q       <= req_key;
            din_q       <= req_data;
            dec_q       <= req_decrypt;
            idx_q       <= '0;
            poll_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= 1'b1;
            sel_q       <= 4'hF;
            if (cache_hit) begin
              state_q <= WR_DIN;
              adr_q   <= BASE_ADDR + OFS_DIN;
              dat_q   <= word_of(req_data, 2'd0);
            end else begin
              state_q <= WR_KEY;
              adr_q   <= BASE_ADDR;
              dat_q   <= word_of(req_key, 2'd0);
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WR_KEY: if (bus_ack) begin
          idx_q <= idx_n;
          if (idx_q == 2'd3) begin
            state_q <= WR_DIN;
            adr_q   <= BASE_ADDR + OFS_DIN;
            dat_q   <= word_of(din_q, 2'd0);
          end else begin
            adr_q <= BASE_ADDR + nxt_ofs;
            dat_q <= word_of(key_q, idx_n);
          end
        end
        WR_DIN: if (bus_ack) begin
          idx_q <= idx_n;
          if (idx_q == 2'd3) begin
            state_q <= WR_CTRL;
            adr_q   <= BASE_ADDR + OFS_CTRL;
            dat_q   <= {30'd0, dec_q, 1'b1};
          end else begin
            adr_q <= BASE_ADDR + OFS_DIN + nxt_ofs;
            dat_q <= word_of(din_q, idx_n);
          end
        end
        WR_CTRL: if (bus_ack) begin
          state_q <= RD_STAT;
          adr_q   <= BASE_ADDR + OFS_STAT;
          dat_q   <= '0;
          we_q    <= 1'b0;
        end
        RD_STAT: if (bus_ack) begin
          if (wbm_dat_i[0]) begin
            state_q <= RD_DOUT;
            adr_q   <= BASE_ADDR + OFS_DOUT;
            idx_q   <= '0;
          end else begin
            poll_q <= poll_q + 8'd1;
          end
        end
        RD_DOUT: if (bus_ack) begin
          rsp_data_q[{~idx_q, 5'd0} +: 32] <= wbm_dat_i;
          idx_q <= idx_n;
          if (idx_q == 2'd3) begin
            state_q     <= RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else begin
            adr_q <= BASE_ADDR + OFS_DOUT + nxt_ofs;
          end
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;

endmodule
